tl_a_arbiter: RTL and testbench
===============================

# tl_a_arbiter

Round-robin arbiter that shares one TileLink A channel between `NumHosts` requesters, such as the per-core and DMA links in front of the cache-coherent crossbar. Multi-beat messages are never interleaved: a host holds the channel until its last beat. No payload buffering; the A path is combinational, and arbitration state is registered. Sits between the source shifters and the host aggregator's A channel. D-channel routing is not part of this block.

## Interface
- `NumHosts`, default 3: number of requesting hosts (≥2).
- `DataWidth`, default 128: A-channel data width in bits; `DataWidth/8` must be a power of two.
- `SizeWidth`, default 3: width of `a_size`.
- `PayloadWidth`, default 200: width of the opaque A payload (address, source, mask, data, param, corrupt), forwarded untouched.
- `MaxSize`, default 6: largest legal `a_size` (log2 bytes).

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `host_a_valid_i` in `[NumHosts-1:0]`: per-host valid.
- `host_a_ready_o` out `[NumHosts-1:0]`: per-host ready.
- `host_a_opcode_i` in `[NumHosts-1:0][2:0]`: per-host opcode.
- `host_a_size_i` in `[NumHosts-1:0][SizeWidth-1:0]`: per-host size.
- `host_a_payload_i` in `[NumHosts-1:0][PayloadWidth-1:0]`: per-host payload.
- `device_a_valid_o` out 1: output valid.
- `device_a_ready_i` in 1: downstream ready.
- `device_a_opcode_o` out 3: output opcode.
- `device_a_size_o` out `SizeWidth`: output size.
- `device_a_payload_o` out `PayloadWidth`: output payload.
- `grant_idx_o` out `$clog2(NumHosts)`: index of the host currently selected (debug/HPM).
- `locked_o` out 1: a multi-beat burst is in progress.

## Operation
- State: `locked` (1 bit), `owner` (index), `beats_left` (counter, width `MaxSize - log2(DataWidth/8)` + 1), `rr_ptr` (index of the highest-priority host).
- Beat count: opcodes 0–3 (PutFullData, PutPartialData, ArithmeticData, LogicalData) carry data.
  - beats = `2^(size - log2(DataWidth/8))` if `size > log2(DataWidth/8)`, else 1.
  - All other opcodes take 1 beat.
- IDLE (`locked`=0):
  - Select the first valid host scanning `rr_ptr`, `rr_ptr+1`, … modulo `NumHosts`.
  - Forward its opcode, size and payload; assert `device_a_valid_o`.
  - Only the winner's `host_a_ready_o` follows `device_a_ready_i`; all others are 0.
- On the first handshake (valid & ready):
  - If beats > 1: `locked`←1, `owner`←winner, `beats_left`←beats-1.
  - In every case, `rr_ptr`←winner+1 (wrapping at `NumHosts-1`→0).
- LOCKED:
  - Mux is forced to `owner` and other hosts see ready=0.
  - Each handshake decrements `beats_left`.
  - The handshake with `beats_left`=1 clears `locked`.
- When no host is valid: `device_a_valid_o`=0, `grant_idx_o` = `rr_ptr`, and payload outputs are don't-care (drive the `rr_ptr` host's payload).
- The choice is stable while `device_a_valid_o`=1 and `device_a_ready_i`=0:
  - `rr_ptr` only moves on a handshake.
  - Hosts obey TileLink and hold valid, so the winner cannot change.
- Illegal stimulus, flagged by an assertion and otherwise undefined:
  - the owner deasserting valid mid-burst;
  - `a_size > MaxSize`.

## Timing
- Zero-cycle latency from host to device: valid, payload and ready are combinational through the mux.
- No bubble between messages: the cycle after a last beat re-arbitrates with the updated `rr_ptr`.
- A single-beat message and the next arbitration can complete in consecutive cycles.
- Reset (async assert, sync release): `locked`=0, `owner`=0, `beats_left`=0, `rr_ptr`=0.
- While `rst_ni`=0, all outputs are forced inactive: `device_a_valid_o`=0, `host_a_ready_o`=0, `locked_o`=0, `grant_idx_o`=0.
- Reset mid-burst drops the lock; the upstream is reset together with this block.
- Simultaneous events:
  - Last beat plus new requests in the same cycle: the new requests are evaluated next cycle.
  - A host whose single-beat message wins while other hosts are valid does not win again until every other valid host has been served.

## Structure
- Put the opcode constants and the `has_data(opcode)` function in the shared TileLink package (`tl_pkg`), not local to this block.
- The beat-count helper `beats(size, DataWidth)` belongs in `tl_pkg` for reuse by the adapters.
- One sub-module: `rr_arbiter` (N-way rotating-priority pick with `rr_ptr` input, one-hot and index outputs).

## Test plan
- **Reset:** assert `rst_ni`=0 with all hosts valid → `device_a_valid_o`=0, all `host_a_ready_o`=0; after release, host 0 is granted first.
- **Round-robin:** `NumHosts`=3, all hosts valid with single-beat Get (opcode 4, size 3), ready=1 → grants 0,1,2,0,1,2 on consecutive cycles.
- **Burst lock:** host 1 sends PutFullData size 6 at `DataWidth`=128 (4 beats) while host 0 and host 2 are valid → 4 consecutive beats from host 1, `locked_o`=1 for 3 cycles, then host 2 is granted.
- **Backpressure:** `device_a_ready_i`=0 for 5 cycles mid-burst, at beat 2 → `beats_left` holds at 2, owner unchanged, no other host gets ready.
- **Size boundary:** PutFullData size 4 (one 16 B beat) → no lock, `rr_ptr` advances; Get size 6 → single beat, no lock.
- **Reset mid-burst:** assert reset after beat 2 of 4 → `locked`=0 and `rr_ptr`=0 immediately, and a fresh arbitration follows release.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared TileLink definitions: A-channel opcodes and beat-count helpers
// used by the arbiter and the width adapters.
package tl_pkg;

   typedef enum logic [2:0] {
      PutFullData    = 3'd0,
      PutPartialData = 3'd1,
      ArithmeticData = 3'd2,
      LogicalData    = 3'd3,
      Get            = 3'd4,
      Intent         = 3'd5,
      AcquireBlock   = 3'd6,
      AcquirePerm    = 3'd7
   } a_opcode_e;

   function automatic logic has_data(input logic [2:0] opcode);
      return opcode inside {PutFullData, PutPartialData, ArithmeticData, LogicalData};
   endfunction

   // Number of bus beats a data-carrying message of 2^size bytes needs.
   function automatic int unsigned beats(input int unsigned size, input int unsigned data_width);
      int unsigned lg;
      lg = $clog2(data_width / 8);
      if (size > lg) return 32'd1 << (size - lg);
      return 32'd1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way rotating-priority pick: first requester at or after ptr wins.
module rr_arbiter #(
   parameter int N    = 3,
   parameter int IdxW = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [IdxW-1:0] ptr,
   output logic [N-1:0]    gnt,
   output logic [IdxW-1:0] idx,
   output logic            any
);

   always_comb begin
      int j;
      gnt = '0;
      idx = ptr;
      any = 1'b0;
      j   = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = IdxW'(j);
         end
      end
   end

endmodule

// File: rtl/tl_a_arbiter.sv
// Round-robin arbiter sharing one TileLink A channel among NumHosts hosts;
// multi-beat messages hold the channel until their last beat.
module tl_a_arbiter
   import tl_pkg::*;
#(
   parameter int NumHosts     = 3,
   parameter int DataWidth    = 128,
   parameter int SizeWidth    = 3,
   parameter int PayloadWidth = 200,
   parameter int MaxSize      = 6
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic [NumHosts-1:0]                   host_a_valid_i,
   output logic [NumHosts-1:0]                   host_a_ready_o,
   input  logic [NumHosts-1:0][2:0]              host_a_opcode_i,
   input  logic [NumHosts-1:0][SizeWidth-1:0]    host_a_size_i,
   input  logic [NumHosts-1:0][PayloadWidth-1:0] host_a_payload_i,
   output logic                                  device_a_valid_o,
   input  logic                                  device_a_ready_i,
   output logic [2:0]                            device_a_opcode_o,
   output logic [SizeWidth-1:0]                  device_a_size_o,
   output logic [PayloadWidth-1:0]               device_a_payload_o,
   output logic [$clog2(NumHosts)-1:0]           grant_idx_o,
   output logic                                  locked_o
);

   localparam int IdxW  = $clog2(NumHosts);
   localparam int BeatW = MaxSize - $clog2(DataWidth / 8) + 1;

   logic             locked;
   logic [IdxW-1:0]  owner;
   logic [BeatW-1:0] beats_left;
   logic [IdxW-1:0]  rr_ptr;

   logic [NumHosts-1:0] arb_gnt;
   logic [IdxW-1:0]     arb_idx;
   logic                arb_any;
   logic [IdxW-1:0]     sel;
   logic                sel_valid;
   logic                fire;
   logic [BeatW-1:0]    nbeats;

   rr_arbiter #(.N(NumHosts), .IdxW(IdxW)) u_rr (
      .req (host_a_valid_i),
      .ptr (rr_ptr),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   // With no requester, the mux parks on rr_ptr so grant_idx_o reports it.
   always_comb begin
      sel       = locked ? owner : arb_idx;
      sel_valid = locked ? host_a_valid_i[owner] : arb_any;
      nbeats    = BeatW'(1);
      if (has_data(host_a_opcode_i[sel]))
         nbeats = BeatW'(beats(32'(host_a_size_i[sel]), DataWidth));
   end

   assign device_a_valid_o   = rst_ni & sel_valid;
   assign device_a_opcode_o  = host_a_opcode_i[sel];
   assign device_a_size_o    = host_a_size_i[sel];
   assign device_a_payload_o = host_a_payload_i[sel];
   assign grant_idx_o        = rst_ni ? sel : '0;
   assign locked_o           = rst_ni & locked;
   assign fire               = device_a_valid_o & device_a_ready_i;

   always_comb begin
      host_a_ready_o = '0;
      if (device_a_valid_o) host_a_ready_o[sel] = device_a_ready_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         locked     <= 1'b0;
         owner      <= '0;
         beats_left <= '0;
         rr_ptr     <= '0;
      end else if (fire) begin
         if (!locked) begin
            rr_ptr <= (sel == IdxW'(NumHosts - 1)) ? '0 : IdxW'(sel + 1'b1);
            if (nbeats > BeatW'(1)) begin
               locked     <= 1'b1;
               owner      <= sel;
               beats_left <= nbeats - BeatW'(1);
            end
         end else begin
            beats_left <= beats_left - BeatW'(1);
            if (beats_left == BeatW'(1)) locked <= 1'b0;
         end
      end
   end

   a_owner_holds_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
      locked |-> host_a_valid_i[owner]);
   a_size_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
      device_a_valid_o |-> (int'(device_a_size_o) <= MaxSize));

endmodule

// File: tb/tb_tl_a_arbiter.sv
// Directed bench for tl_a_arbiter: reset, round-robin, burst lock,
// backpressure, size boundaries and reset mid-burst.
module tb_tl_a_arbiter;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [2:0]        valid;
   logic [2:0]        ready;
   logic [2:0][2:0]   opc;
   logic [2:0][2:0]   siz;
   logic [2:0][199:0] pay;
   logic              dv;
   logic              dr;
   logic [2:0]        dop;
   logic [2:0]        dsz;
   logic [199:0]      dpay;
   logic [1:0]        gidx;
   logic              lck;
   int                total = 0;
   int                bad   = 0;

   always #5 clk = ~clk;

   tl_a_arbiter dut (
      .clk_i              (clk),
      .rst_ni             (rst_n),
      .host_a_valid_i     (valid),
      .host_a_ready_o     (ready),
      .host_a_opcode_i    (opc),
      .host_a_size_i      (siz),
      .host_a_payload_i   (pay),
      .device_a_valid_o   (dv),
      .device_a_ready_i   (dr),
      .device_a_opcode_o  (dop),
      .device_a_size_o    (dsz),
      .device_a_payload_o (dpay),
      .grant_idx_o        (gidx),
      .locked_o           (lck)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic host(input int i, input logic v, input logic [2:0] op, input logic [2:0] sz);
      valid[i] = v;
      opc[i]   = op;
      siz[i]   = sz;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      dr    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         pay[i] = 200'h100 + 200'(i);
         host(i, 1'b1, 3'd4, 3'd3);
      end

      // reset with every host requesting
      nxt(); nxt(); #2;
      chk("rst_valid", 256'(dv), 256'd0);
      chk("rst_ready", 256'(ready), 256'd0);
      chk("rst_grant", 256'(gidx), 256'd0);
      chk("rst_locked", 256'(lck), 256'd0);
      nxt();
      rst_n = 1'b1;

      // round-robin over single-beat Gets
      for (int c = 0; c < 6; c++) begin
         #2;
         chk("rr_grant", 256'(gidx), 256'(c % 3));
         chk("rr_ready", 256'(ready), 256'(3'b001 << (c % 3)));
         chk("rr_payload", 256'(dpay), 256'(200'h100 + 200'(c % 3)));
         nxt();
      end

      // host 0 takes one Get, then host 1 bursts 4 beats
      host(1, 1'b1, 3'd0, 3'd6);
      #2;
      chk("pre_grant", 256'(gidx), 256'd0);
      nxt(); #2;
      chk("b1_grant", 256'(gidx), 256'd1);
      chk("b1_locked", 256'(lck), 256'd0);
      chk("b1_ready", 256'(ready), 256'(3'b010));
      nxt(); #2;
      chk("b2_grant", 256'(gidx), 256'd1);
      chk("b2_locked", 256'(lck), 256'd1);
      nxt();
      dr = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #2;
         chk("bp_beats_left", 256'(dut.beats_left), 256'd2);
         chk("bp_grant", 256'(gidx), 256'd1);
         chk("bp_ready", 256'(ready), 256'd0);
         chk("bp_valid", 256'(dv), 256'd1);
         nxt();
      end
      dr = 1'b1;
      #2;
      chk("b3_locked", 256'(lck), 256'd1);
      chk("b3_beats_left", 256'(dut.beats_left), 256'd2);
      nxt(); #2;
      chk("b4_locked", 256'(lck), 256'd1);
      chk("b4_beats_left", 256'(dut.beats_left), 256'd1);
      chk("b4_ready", 256'(ready), 256'(3'b010));
      nxt(); #2;
      chk("post_grant", 256'(gidx), 256'd2);
      chk("post_locked", 256'(lck), 256'd0);
      chk("post_ready", 256'(ready), 256'(3'b100));
      nxt();

      // size boundary: 16 B put and 64 B get are single beats
      host(0, 1'b1, 3'd0, 3'd4);
      host(1, 1'b0, 3'd4, 3'd3);
      host(2, 1'b0, 3'd4, 3'd3);
      #2;
      chk("sz4_grant", 256'(gidx), 256'd0);
      nxt(); #2;
      chk("sz4_locked", 256'(lck), 256'd0);
      chk("sz4_rr_ptr", 256'(dut.rr_ptr), 256'd1);
      host(0, 1'b1, 3'd4, 3'd6);
      #1;
      chk("get6_grant", 256'(gidx), 256'd0);
      nxt(); #2;
      chk("get6_locked", 256'(lck), 256'd0);
      chk("get6_rr_ptr", 256'(dut.rr_ptr), 256'd1);
      host(0, 1'b0, 3'd4, 3'd3);
      #1;
      chk("idle_valid", 256'(dv), 256'd0);
      chk("idle_grant", 256'(gidx), 256'd1);
      nxt();

      // reset after beat 2 of a 4-beat burst
      host(1, 1'b1, 3'd0, 3'd6);
      nxt(); nxt(); #2;
      chk("mid_locked", 256'(lck), 256'd1);
      rst_n = 1'b0;
      #1;
      chk("mrst_locked", 256'(dut.locked), 256'd0);
      chk("mrst_rr_ptr", 256'(dut.rr_ptr), 256'd0);
      chk("mrst_valid", 256'(dv), 256'd0);
      chk("mrst_ready", 256'(ready), 256'd0);
      nxt();
      rst_n = 1'b1;
      host(0, 1'b1, 3'd4, 3'd3);
      #2;
      chk("fresh_grant", 256'(gidx), 256'd0);
      chk("fresh_ready", 256'(ready), 256'(3'b001));
      chk("fresh_locked", 256'(lck), 256'd0);
      nxt(); #2;
      chk("fresh2_grant", 256'(gidx), 256'd1);
      chk("fresh2_locked", 256'(lck), 256'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
